uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//   Serial-to-parallel UART receive stage; consumes the line driven by the transmitter (its y output).
//   Frame: idle-high line, 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1), no parity.
//   Generates its own oversampling tick, samples each bit at mid-bit and presents the byte on a
//   one-entry valid/ready holding register. Errors are flagged per byte.
// PARAMETERS
//   CLK_FREQ    100_000_000  system clock frequency, Hz
//   BAUD        9600         line bit rate, bits/s
//   OVERSAMPLE  16           sample ticks per bit; must be even and >= 8
//   DATA_BITS   8            data bits per frame (5..8)
// PORTS
//   clk        in   1          system clock, all logic on rising edge
//   reset      in   1          asynchronous, active-low reset (0 = reset asserted)
//   rx         in   1          asynchronous serial line input, idle high
//   rx_ready   in   1          consumer accepts rx_data when rx_valid && rx_ready
//   rx_data    out  DATA_BITS  received byte; held stable while rx_valid=1
//   rx_valid   out  1          holding register full
//   frame_err  out  1          stop bit sampled 0 for the byte in the holding register
//   overrun    out  1          sticky: a byte was dropped because the holding register was full
//   busy       out  1          frame reception in progress (state != IDLE)
// BEHAVIOUR
//   Reset: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, all counters=0,
//     synchronizer flops=1. Reset asserted mid-frame aborts the frame; no partial byte is delivered.
//   Sync: rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s only.
//   Tick: one-clk pulse every TICK_DIV = CLK_FREQ/(BAUD*OVERSAMPLE) clocks (integer floor; default 651).
//     The divider free-runs and is not re-phased by start detection.
//   FSM (advances only on tick, except IDLE->START):
//     IDLE : on tick with rx_s=0 -> START, sample_cnt=0.
//     START: on tick sample_cnt++; at sample_cnt=OVERSAMPLE/2-1: rx_s=1 -> IDLE (glitch rejected),
//            else -> DATA, sample_cnt=0, bit_idx=0.
//     DATA : at sample_cnt=OVERSAMPLE-1 shift rx_s into shift reg MSB (LSB-first arrival), bit_idx++,
//            sample_cnt=0; after bit DATA_BITS-1 -> STOP.
//     STOP : at sample_cnt=OVERSAMPLE-1 sample stop bit -> commit, then IDLE (no wait for line high;
//            a following start bit is detected on the next tick with rx_s=0).
//   Commit (1 clk): if rx_valid=0 or (rx_valid && rx_ready in the same clk): rx_data<=shift reg,
//     frame_err<=~stop_sample, rx_valid<=1. Otherwise the new byte is discarded, overrun<=1,
//     held byte and frame_err unchanged.
//   Handshake: rx_valid && rx_ready -> rx_valid<=0 next clk unless a commit happens that clk.
//     rx_ready while rx_valid=0 has no effect. overrun clears only on reset.
//   Latency: rx_valid rises 1 clk after the mid-point tick of the stop bit
//     (about 9.5 bit times after the start-bit falling edge, plus 2-3 clks of sync/tick phase).
//   Break (line held 0): frame completes with frame_err=1, rx_data=0; the FSM then re-enters START
//     and rejects nothing until the line returns high; each further frame is also flagged.
// STRUCTURE
//   uart_pkg: rx_state_t enum {IDLE, START, DATA, STOP}; default CLK_FREQ/BAUD/OVERSAMPLE constants.
//     The transmitter shares these constants.
//   Sub-module uart_baud_tick_gen (parameters CLK_FREQ, BAUD, OVERSAMPLE; ports clk, reset, tick).
//     The FSM, shift register, counters, synchronizer and holding register live in uart_receiver.
// TESTING  (bench drives rx with a bit-accurate model at BAUD; rx_ready=1 unless stated)
//   1 Frame 0x77, stop=1 -> rx_data=8'h77, rx_valid pulses 1 clk, frame_err=0, overrun=0.
//   2 Back-to-back frames 0x77 then 0x7F, zero idle gap -> two valid pulses, data 8'h77 then 8'h7F.
//   3 Frame 0xA5 with stop bit driven 0 -> rx_data=8'hA5, frame_err=1; next good frame clears frame_err.
//   4 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 8'h11, rx_valid=1, overrun=1;
//     raise rx_ready -> 0x11 accepted, rx_valid=0.
//   5 0-pulse on rx lasting 3 ticks (< OVERSAMPLE/2) -> FSM returns to IDLE, no rx_valid, busy drops.
//   6 Assert reset after 4 data bits of 0x3C, release, send 0x5A -> only 8'h5A delivered;
//     all outputs 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver state encoding; the transmitter uses the same defaults.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int UART_CLK_FREQ  = 100_000_000;
  localparam int UART_BAUD      = 9600;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS = 8;

  // Clocks per oversample tick, integer floor.
  function automatic int tick_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Free-running oversample tick: one-clock pulse every CLK_FREQ/(BAUD*OVERSAMPLE) clocks.
module uart_baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = UART_CLK_FREQ,
  parameter int BAUD       = UART_BAUD,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DW = $clog2(TICK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop sync, oversampled mid-bit sampling, one-entry valid/ready holding register.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = UART_CLK_FREQ,
  parameter int BAUD       = UART_BAUD,
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] SC_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] SC_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] BI_LAST = IW'(DATA_BITS - 1);

  logic                 tick;
  logic                 rx_meta, rx_s;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q;
  logic                 shift_en, commit;

  uart_baud_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Synchronizer resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      if (shift_en) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_en = 1'b0;
    commit   = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
        START: if (cnt_q == SC_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;  // line back high at mid start bit: glitch
        end else cnt_d = cnt_q + 1'b1;
        DATA: if (cnt_q == SC_LAST) begin
          cnt_d    = '0;
          shift_en = 1'b1;
          bit_d    = bit_q + 1'b1;
          if (bit_q == BI_LAST) state_d = STOP;
        end else cnt_d = cnt_q + 1'b1;
        STOP: if (cnt_q == SC_LAST) begin
          cnt_d   = '0;
          commit  = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q + 1'b1;
        default: state_d = IDLE;
      endcase
    end
  end

  // A commit may land in the same clock the consumer drains the old byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (commit) begin
      if (!rx_valid || rx_ready) begin
        rx_data   <= shift_q;
        frame_err <= ~rx_s;
        rx_valid  <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: bit-accurate line model, handshake monitor, per-scenario checks.
module tb_uart_receiver;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD      = 12_500;
  localparam int OS        = 16;
  localparam int DB        = 8;
  localparam int TICK_CLKS = 8;     // 1_600_000 / (12_500 * 16)
  localparam int BIT_CLKS  = 128;   // TICK_CLKS * OS

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, overrun, busy;

  int errors = 0;
  int checks = 0;
  int valid_cycles = 0;
  logic [8:0] cap_q[$];   // {frame_err, rx_data} at each accepted handshake

  uart_receiver #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS),
    .DATA_BITS (DB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Inputs change on negedge, so values read here are the ones the DUT sees at this edge.
  always @(posedge clk) begin
    if (rx_valid) valid_cycles <= valid_cycles + 1;
    if (rx_valid && rx_ready) cap_q.push_back({frame_err, rx_data});
  end

  task automatic drive_bits(input logic v, input int nclk);
    rx = v;
    repeat (nclk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bits(1'b0, BIT_CLKS);
    for (int i = 0; i < DB; i++) drive_bits(d[i], BIT_CLKS);
    drive_bits(stop_bit, BIT_CLKS);
    rx = 1'b1;
  endtask

  task automatic wait_caps(input int n);
    int t = 0;
    while (cap_q.size() < n && t < 4000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (cap_q.size() < n) begin
      errors++;
      $display("FAIL wait_caps: got %0d bytes, want %0d", cap_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_single();
    int base = cap_q.size();
    int vc = valid_cycles;
    send_frame(8'h77, 1'b1);
    wait_caps(base + 1);
    repeat (BIT_CLKS) @(negedge clk);
    checks++; if (cap_q.size() !== base + 1) begin errors++; $display("FAIL single_count: got %0d want %0d", cap_q.size(), base + 1); end
    checks++; if (cap_q[base] !== {1'b0, 8'h77}) begin errors++; $display("FAIL single_data: got %h want 077", cap_q[base]); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL single_frame_err: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL single_overrun: got %b want 0", overrun); end
    checks++; if (valid_cycles - vc !== 1) begin errors++; $display("FAIL single_pulse: got %0d valid clks want 1", valid_cycles - vc); end
  endtask

  task automatic test_back_to_back();
    int base = cap_q.size();
    send_frame(8'h77, 1'b1);
    send_frame(8'h7F, 1'b1);
    wait_caps(base + 2);
    repeat (BIT_CLKS) @(negedge clk);
    checks++; if (cap_q.size() !== base + 2) begin errors++; $display("FAIL b2b_count: got %0d want %0d", cap_q.size(), base + 2); end
    checks++; if (cap_q[base] !== {1'b0, 8'h77}) begin errors++; $display("FAIL b2b_first: got %h want 077", cap_q[base]); end
    checks++; if (cap_q[base+1] !== {1'b0, 8'h7F}) begin errors++; $display("FAIL b2b_second: got %h want 07f", cap_q[base+1]); end
  endtask

  task automatic test_frame_err();
    int base = cap_q.size();
    send_frame(8'hA5, 1'b0);
    wait_caps(base + 1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (cap_q[base] !== {1'b1, 8'hA5}) begin errors++; $display("FAIL ferr_byte: got %h want 1a5", cap_q[base]); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL ferr_data: got %h want a5", rx_data); end
    send_frame(8'h96, 1'b1);
    wait_caps(base + 2);
    repeat (BIT_CLKS) @(negedge clk);
    checks++; if (cap_q.size() !== base + 2) begin errors++; $display("FAIL ferr_count: got %0d want %0d", cap_q.size(), base + 2); end
    checks++; if (cap_q[base+1] !== {1'b0, 8'h96}) begin errors++; $display("FAIL ferr_clear_byte: got %h want 096", cap_q[base+1]); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear_flag: got %b want 0", frame_err); end
  endtask

  task automatic test_glitch();
    int base = cap_q.size();
    drive_bits(1'b0, 3 * TICK_CLKS);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
    rx = 1'b1;
    repeat (20 * TICK_CLKS) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b want 0", busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    checks++; if (cap_q.size() !== base) begin errors++; $display("FAIL glitch_count: got %0d want %0d", cap_q.size(), base); end
  endtask

  task automatic test_overrun();
    int base = cap_q.size();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    send_frame(8'h22, 1'b1);
    repeat (BIT_CLKS) @(negedge clk);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
    checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h want 11", rx_data); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    checks++; if (cap_q.size() !== base) begin errors++; $display("FAIL ovr_no_accept: got %0d want %0d", cap_q.size(), base); end
    rx_ready = 1'b1;
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid: got %b want 0", rx_valid); end
    checks++; if (cap_q[base] !== {1'b0, 8'h11}) begin errors++; $display("FAIL ovr_drain_byte: got %h want 011", cap_q[base]); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_abort();
    int base = cap_q.size();
    logic [7:0] d = 8'h3C;
    drive_bits(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bits(d[i], BIT_CLKS);
    reset = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL abort_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL abort_rx_data: got %h want 00", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL abort_frame_err: got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0)   begin errors++; $display("FAIL abort_overrun: got %b want 0", overrun); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    reset = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    wait_caps(base + 1);
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++; if (cap_q.size() !== base + 1) begin errors++; $display("FAIL abort_count: got %0d want %0d", cap_q.size(), base + 1); end
    checks++; if (cap_q[base] !== {1'b0, 8'h5A}) begin errors++; $display("FAIL abort_byte: got %h want 05a", cap_q[base]); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
